// File: rtl/truth_table_evaluator_if.sv
// Bus between the truth-table evaluator, the GA controller and the logic array under test.
// slave is the evaluator side; master is the controller/array side.
interface truth_table_evaluator_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 1
);
    localparam int TT_W    = (2 ** N_IN) * N_OUT;
    localparam int SCORE_W = $clog2(TT_W + 1);

    logic                  start;
    logic [TT_W-1:0]       target;
    logic [N_IN-1:0]       stim;
    logic [N_OUT-1:0]      resp;
    logic                  busy;
    logic                  done;
    logic [SCORE_W-1:0]    score;
    logic [2**N_IN-1:0]    err_map;

    modport master (
        output start, target, resp,
        input  stim, busy, done, score, err_map
    );

    modport slave (
        input  start, target, resp,
        output stim, busy, done, score, err_map
    );
endinterface

// File: rtl/truth_table_evaluator.sv
// Drives every input pattern onto an evolved logic array, samples its outputs after a
// settle time and scores them against a latched target truth table.
module truth_table_evaluator #(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 4
) (
    input  logic                   FPGA_CLK_50,
    input  logic                   RST_N,
    truth_table_evaluator_if.slave bus
);
    localparam int NPAT    = 2 ** N_IN;
    localparam int TT_W    = NPAT * N_OUT;
    localparam int SCORE_W = $clog2(TT_W + 1);
    localparam logic [N_IN:0] LAST_PAT    = (N_IN + 1)'(NPAT - 1);
    localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t             state;
    logic [TT_W-1:0]    tgt;
    logic [N_IN:0]      pattern;
    logic [7:0]         settle_cnt;
    logic [N_OUT-1:0]   expected;
    logic [SCORE_W-1:0] hits;
    logic               mismatch;

    always_comb begin
        expected = tgt[int'(pattern[N_IN-1:0]) * N_OUT +: N_OUT];
        mismatch = |(bus.resp ^ expected);
        hits     = '0;
        for (int unsigned i = 0; i < N_OUT; i++)
            hits = hits + SCORE_W'(bus.resp[i] == expected[i]);
    end

    always_ff @(posedge FPGA_CLK_50) begin
        if (!RST_N) begin
            state      <= IDLE;
            bus.stim   <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.score  <= '0;
            bus.err_map <= '0;
            tgt        <= '0;
            pattern    <= '0;
            settle_cnt <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        tgt         <= bus.target;
                        bus.score   <= '0;
                        bus.err_map <= '0;
                        pattern     <= '0;
                        settle_cnt  <= '0;
                        bus.stim    <= '0;
                        bus.busy    <= 1'b1;
                        state       <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    bus.score                       <= bus.score + hits;
                    bus.err_map[pattern[N_IN-1:0]]  <= mismatch;
                    // stim moves to the next pattern on the same edge so its settle window starts at once
                    if (pattern == LAST_PAT) begin
                        bus.stim <= '0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        pattern  <= pattern + 1'b1;
                        bus.stim <= pattern[N_IN-1:0] + 1'b1;
                        state    <= DRIVE;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_truth_table_evaluator.sv
// Bench for truth_table_evaluator: a default instance (4 in / 1 out / settle 4) and a
// 4 in / 2 out / settle 1 instance, checked against a queue of expected results.
module tb_truth_table_evaluator;
    typedef struct {
        int          score;
        logic [15:0] err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   mode_a = 0;
    logic [1:0] resp_b = 2'b11;
    exp_t sb_a[$];
    exp_t sb_b[$];

    always #5 clk = ~clk;

    truth_table_evaluator_if #(.N_IN(4), .N_OUT(1)) bus_a ();
    truth_table_evaluator_if #(.N_IN(4), .N_OUT(2)) bus_b ();

    // array models: 0 = AND4, 1 = NAND4, 2 = AND4 with a stuck-high fault on pattern 5
    function automatic logic model_a(input int md, input logic [3:0] s);
        case (md)
            0:       return &s;
            1:       return ~&s;
            default: return (&s) | (s == 4'd5);
        endcase
    endfunction

    assign bus_a.resp = model_a(mode_a, bus_a.stim);
    assign bus_b.resp = resp_b;

    truth_table_evaluator #(.N_IN(4), .N_OUT(1), .SETTLE(4)) dut_a (
        .FPGA_CLK_50(clk),
        .RST_N      (rst_n),
        .bus        (bus_a.slave)
    );

    truth_table_evaluator #(.N_IN(4), .N_OUT(2), .SETTLE(1)) dut_b (
        .FPGA_CLK_50(clk),
        .RST_N      (rst_n),
        .bus        (bus_b.slave)
    );

    function automatic exp_t expect_a(input logic [15:0] tgt, input int md);
        exp_t e;
        logic r;
        e.score = 0;
        e.err   = '0;
        for (int p = 0; p < 16; p++) begin
            r = model_a(md, 4'(p));
            if (r == tgt[p]) e.score++;
            else             e.err[p] = 1'b1;
        end
        return e;
    endfunction

    function automatic exp_t expect_b(input logic [31:0] tgt, input logic [1:0] r);
        exp_t e;
        e.score = 0;
        e.err   = '0;
        for (int p = 0; p < 16; p++)
            for (int o = 0; o < 2; o++) begin
                if (r[o] == tgt[p*2+o]) e.score++;
                else                    e.err[p] = 1'b1;
            end
        return e;
    endfunction

    // Drives start at a negedge; the following edge is cycle 0 of the run.
    task automatic start_a(input logic [15:0] tgt, input int md);
        @(negedge clk);
        bus_a.target = tgt;
        mode_a       = md;
        bus_a.start  = 1'b1;
        sb_a.push_back(expect_a(tgt, md));
    endtask

    // Waits up to limit cycles past cycle k0 for done; k = cycle of done or -1.
    task automatic wait_done_a(input int k0, input int limit, output int k);
        k = -1;
        for (int i = k0 + 1; i <= k0 + limit; i++) begin
            @(negedge clk);
            if (bus_a.done === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus_a.start  = 1'b0;
        bus_b.start  = 1'b0;
        bus_a.target = '0;
        bus_b.target = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus_a.stim, bus_a.busy, bus_a.done, bus_a.score, bus_a.err_map} !== '0) begin
            bad++;
            $display("FAIL reset_a: got stim=%h busy=%b done=%b score=%0d err=%h, want all 0",
                     bus_a.stim, bus_a.busy, bus_a.done, bus_a.score, bus_a.err_map);
        end
        total++;
        if ({bus_b.stim, bus_b.busy, bus_b.done, bus_b.score, bus_b.err_map} !== '0) begin
            bad++;
            $display("FAIL reset_b: got stim=%h busy=%b done=%b score=%0d err=%h, want all 0",
                     bus_b.stim, bus_b.busy, bus_b.done, bus_b.score, bus_b.err_map);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_and4();
        int   bad_k;
        exp_t e;
        start_a(16'h8000, 0);
        @(negedge clk);
        bus_a.start = 1'b0;
        total++;
        if (bus_a.busy !== 1'b1 || bus_a.stim !== 4'd0) begin
            bad++;
            $display("FAIL and4_cycle1: got busy=%b stim=%h, want busy=1 stim=0", bus_a.busy, bus_a.stim);
        end
        bad_k = -1;
        for (int k = 1; k <= 80; k++) begin
            if (k > 1) @(negedge clk);
            if (bad_k < 0 && (bus_a.stim !== 4'((k - 1) / 5) || bus_a.done !== 1'b0)) bad_k = k;
        end
        total++;
        if (bad_k >= 0) begin
            bad++;
            $display("FAIL and4_stim_seq: first wrong at cycle %0d stim=%h done=%b, want stim=%0d done=0",
                     bad_k, bus_a.stim, bus_a.done, (bad_k - 1) / 5);
        end
        @(negedge clk);
        total++;
        if (bus_a.done !== 1'b1 || bus_a.stim !== 4'd0) begin
            bad++;
            $display("FAIL and4_done81: got done=%b stim=%h at cycle 81, want done=1 stim=0", bus_a.done, bus_a.stim);
        end
        if (sb_a.size() > 0) begin
            e = sb_a.pop_front();
            total++;
            if (bus_a.score !== 5'(e.score) || bus_a.err_map !== e.err) begin
                bad++;
                $display("FAIL and4_result: got score=%0d err=%h, want score=%0d err=%h",
                         bus_a.score, bus_a.err_map, e.score, e.err);
            end
        end
        @(negedge clk);
        total++;
        if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b0) begin
            bad++;
            $display("FAIL and4_after: got done=%b busy=%b at cycle 82, want 0 0", bus_a.done, bus_a.busy);
        end
    endtask

    task automatic test_nand4();
        int   k;
        exp_t e;
        start_a(16'h8000, 1);
        @(negedge clk);
        bus_a.start = 1'b0;
        wait_done_a(1, 200, k);
        total++;
        if (k !== 81) begin
            bad++;
            $display("FAIL nand4_latency: got done at cycle %0d, want 81", k);
        end
        e = sb_a.pop_front();
        total++;
        if (bus_a.score !== 5'(e.score) || bus_a.err_map !== e.err) begin
            bad++;
            $display("FAIL nand4_result: got score=%0d err=%h, want score=%0d err=%h",
                     bus_a.score, bus_a.err_map, e.score, e.err);
        end
    endtask

    task automatic test_single_fault();
        int   k;
        exp_t e;
        start_a(16'h8000, 2);
        @(negedge clk);
        bus_a.start = 1'b0;
        wait_done_a(1, 200, k);
        e = sb_a.pop_front();
        total++;
        if (k !== 81 || bus_a.score !== 5'(e.score) || bus_a.err_map !== e.err) begin
            bad++;
            $display("FAIL fault5_result: got cycle=%0d score=%0d err=%h, want cycle=81 score=%0d err=%h",
                     k, bus_a.score, bus_a.err_map, e.score, e.err);
        end
        // hold: with no new start, results survive idle cycles
        repeat (5) @(negedge clk);
        total++;
        if (bus_a.score !== 5'(e.score) || bus_a.err_map !== e.err || bus_a.busy !== 1'b0) begin
            bad++;
            $display("FAIL fault5_hold: got score=%0d err=%h busy=%b, want score=%0d err=%h busy=0",
                     bus_a.score, bus_a.err_map, bus_a.busy, e.score, e.err);
        end
    endtask

    task automatic test_start_ignored();
        int   n_done;
        int   first;
        exp_t e;
        start_a(16'h8000, 0);
        n_done = 0;
        first  = -1;
        for (int k = 1; k <= 130; k++) begin
            @(negedge clk);
            if (bus_a.done === 1'b1) begin
                n_done++;
                if (first < 0) first = k;
            end
            if (k == 1 || k == 11 || k == 41) bus_a.start = 1'b0;
            if (k == 10 || k == 40) bus_a.start = 1'b1;
            if (k == 20) bus_a.target = 16'h0000;
        end
        bus_a.target = 16'h8000;
        total++;
        if (n_done !== 1 || first !== 81) begin
            bad++;
            $display("FAIL ignore_start: got %0d done pulses, first at %0d, want 1 at 81", n_done, first);
        end
        e = sb_a.pop_front();
        total++;
        if (bus_a.score !== 5'(e.score) || bus_a.err_map !== e.err) begin
            bad++;
            $display("FAIL ignore_target: got score=%0d err=%h, want score=%0d err=%h",
                     bus_a.score, bus_a.err_map, e.score, e.err);
        end
    endtask

    task automatic test_reset_mid();
        int   n_done;
        int   k;
        exp_t e;
        start_a(16'h8000, 0);
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (39) @(negedge clk);
        rst_n = 1'b0;
        sb_a.delete();
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if ({bus_a.stim, bus_a.busy, bus_a.done, bus_a.score, bus_a.err_map} !== '0) begin
            bad++;
            $display("FAIL midreset_clear: got stim=%h busy=%b done=%b score=%0d err=%h, want all 0",
                     bus_a.stim, bus_a.busy, bus_a.done, bus_a.score, bus_a.err_map);
        end
        n_done = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus_a.done === 1'b1 || bus_a.busy === 1'b1) n_done++;
        end
        total++;
        if (n_done !== 0) begin
            bad++;
            $display("FAIL midreset_quiet: got %0d cycles with done/busy after abort, want 0", n_done);
        end
        start_a(16'h8000, 0);
        @(negedge clk);
        bus_a.start = 1'b0;
        wait_done_a(1, 200, k);
        e = sb_a.pop_front();
        total++;
        if (k !== 81 || bus_a.score !== 5'(e.score) || bus_a.err_map !== e.err) begin
            bad++;
            $display("FAIL midreset_rerun: got cycle=%0d score=%0d err=%h, want cycle=81 score=%0d err=%h",
                     k, bus_a.score, bus_a.err_map, e.score, e.err);
        end
    endtask

    task automatic test_back_to_back();
        int   d1;
        int   d2;
        logic busy34;
        logic busy35;
        exp_t e;
        @(negedge clk);
        bus_b.target = 32'hFFFF_FFFF;
        resp_b       = 2'b11;
        bus_b.start  = 1'b1;
        sb_b.push_back(expect_b(32'hFFFF_FFFF, 2'b11));
        sb_b.push_back(expect_b(32'hFFFF_FFFF, 2'b11));
        d1 = -1;
        d2 = -1;
        busy34 = 1'bx;
        busy35 = 1'bx;
        for (int k = 1; k <= 100 && d2 < 0; k++) begin
            @(negedge clk);
            if (k == 34) busy34 = bus_b.busy;
            if (k == 35) busy35 = bus_b.busy;
            if (bus_b.done === 1'b1) begin
                if (d1 < 0) d1 = k;
                else begin
                    d2 = k;
                    bus_b.start = 1'b0;
                end
                total++;
                if (sb_b.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_extra_done: got done at cycle %0d, want no more runs", k);
                end else begin
                    e = sb_b.pop_front();
                    if (bus_b.score !== 6'(e.score) || bus_b.err_map !== e.err) begin
                        bad++;
                        $display("FAIL b2b_result: got score=%0d err=%h, want score=%0d err=%h",
                                 bus_b.score, bus_b.err_map, e.score, e.err);
                    end
                end
            end
        end
        bus_b.start = 1'b0;
        total++;
        if (d1 !== 33 || d2 !== 67) begin
            bad++;
            $display("FAIL b2b_latency: got done at %0d and %0d, want 33 and 67", d1, d2);
        end
        total++;
        if (busy34 !== 1'b0 || busy35 !== 1'b1) begin
            bad++;
            $display("FAIL b2b_restart: got busy=%b,%b at cycles 34,35, want 0,1", busy34, busy35);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_b_slice();
        int   k;
        exp_t e;
        @(negedge clk);
        bus_b.target = 32'h0000_FFFF;
        resp_b       = 2'b11;
        bus_b.start  = 1'b1;
        sb_b.push_back(expect_b(32'h0000_FFFF, 2'b11));
        @(negedge clk);
        bus_b.start = 1'b0;
        k = -1;
        for (int i = 2; i <= 100; i++) begin
            @(negedge clk);
            if (bus_b.done === 1'b1) begin
                k = i;
                break;
            end
        end
        e = sb_b.pop_front();
        total++;
        if (k !== 33 || bus_b.score !== 6'(e.score) || bus_b.err_map !== e.err) begin
            bad++;
            $display("FAIL b_slice: got cycle=%0d score=%0d err=%h, want cycle=33 score=%0d err=%h",
                     k, bus_b.score, bus_b.err_map, e.score, e.err);
        end
    endtask

    initial begin
        test_reset();
        test_and4();
        test_nand4();
        test_single_fault();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_b_slice();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
